// File: rtl/early_debounce_pkg.sv
// Shared types and default timing constants for the early-detection debouncer.
package early_debounce_pkg;

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    localparam int DB_TICK_M     = 100000;
    localparam int DB_LOCK_TICKS = 20;

endpackage

// File: rtl/early_debounce_ctrl_chan.sv
// One debounce channel: 2-flop synchroniser, lockout FSM, tick-driven lockout
// counter and registered edge pulses.
module debounce_chan
    import early_debounce_pkg::*;
#(
    parameter int LOCK_TICKS = DB_LOCK_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    input  logic tick,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int             CW       = $clog2(LOCK_TICKS + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LOCK_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(1);

    logic [1:0]    sync_q, sync_d;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          s;

    assign s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= ZERO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Pulses are flagged on the accepting transition so they register
    // together with the new state and line up with db_out.
    always_comb begin
        sync_d  = {sync_q[0], sw_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                    rise_d  = 1'b1;
                end
            end
            WAIT1: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) state_d = ONE;
                    cnt_d = cnt_q - CNT_LAST;
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                    fall_d  = 1'b1;
                end
            end
            WAIT0: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) state_d = ZERO;
                    cnt_d = cnt_q - CNT_LAST;
                end
            end
            default: state_d = ZERO;
        endcase
    end

    assign db_out     = (state_q == WAIT1) || (state_q == ONE);
    assign busy       = (state_q == WAIT1) || (state_q == WAIT0);
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/early_debounce_ctrl.sv
// Multi-channel early-detection debouncer: a free-running tick prescaler
// shared by CH independent lockout channels.
module early_debounce_ctrl
    import early_debounce_pkg::*;
#(
    parameter int CH         = 4,
    parameter int TICK_M     = DB_TICK_M,
    parameter int LOCK_TICKS = DB_LOCK_TICKS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw_in,
    output logic [CH-1:0] db_out,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse,
    output logic [CH-1:0] busy,
    output logic          tick
);

    localparam int            PW      = $clog2(TICK_M);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_M - 1);

    logic [PW-1:0] ps_q, ps_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ps_q <= '0;
        else       ps_q <= ps_d;
    end

    always_comb begin
        ps_d = tick ? '0 : ps_q + PW'(1);
    end

    assign tick = (ps_q == PS_LAST);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        debounce_chan #(
            .LOCK_TICKS (LOCK_TICKS)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .sw_in      (sw_in[i]),
            .tick       (tick),
            .db_out     (db_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_early_debounce_ctrl.sv
// Bench for early_debounce_ctrl: cycle scoreboard fed by a behavioural model
// plus directed checks on latency, lockout length, bounce and reset abort.
module tb_early_debounce_ctrl;

    localparam int CH = 2;
    localparam int M  = 4;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] sw_in = '0;
    logic [CH-1:0] db_out, rise_pulse, fall_pulse, busy;
    logic          tick;

    early_debounce_ctrl #(.CH(CH), .TICK_M(M), .LOCK_TICKS(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_in      (sw_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: input seen two clocks late, level follows the first
    // change, then a lockout of L ticks during which the input is ignored.
    int            p;
    int            lock [CH];
    logic [CH-1:0] m1, m2, lvl, mrise, mfall, mbusy;
    logic          tk;
    logic [31:0]   exp_q [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p = 0; m1 = '0; m2 = '0; lvl = '0; mrise = '0; mfall = '0;
            for (int i = 0; i < CH; i++) lock[i] = 0;
            exp_q.delete();
        end else begin
            tk = (p == M - 1);
            p  = (p + 1) % M;
            for (int i = 0; i < CH; i++) begin
                mrise[i] = 1'b0;
                mfall[i] = 1'b0;
                if (lock[i] == 0) begin
                    if (m2[i] != lvl[i]) begin
                        lvl[i]   = m2[i];
                        lock[i]  = L;
                        mrise[i] = m2[i];
                        mfall[i] = !m2[i];
                    end
                end else if (tk) begin
                    lock[i] = lock[i] - 1;
                end
                mbusy[i] = (lock[i] != 0);
            end
            m2 = m1;
            m1 = sw_in;
            exp_q.push_back({23'b0, lvl, mrise, mfall, mbusy, (p == M - 1)});
        end
    end

    int          rise_cnt [CH];
    int          fall_cnt [CH];
    logic [31:0] e;

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb", {23'b0, db_out, rise_pulse, fall_pulse, busy, tick}, e);
            for (int i = 0; i < CH; i++) begin
                rise_cnt[i] += int'(rise_pulse[i]);
                fall_cnt[i] += int'(fall_pulse[i]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < CH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    endtask

    int   nb;
    int   one_cyc;
    logic db_low;
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        clr_cnt();
        cyc(2);
        chk("rst_outs", {db_out, rise_pulse, fall_pulse, busy, tick}, 0);
        reset = 1'b0;

        // 1: idle input
        cyc(50);
        chk("t1_db", db_out, 0);
        chk("t1_rise", rise_cnt[0] + rise_cnt[1], 0);
        chk("t1_fall", fall_cnt[0] + fall_cnt[1], 0);

        // 2: press latency and lockout length
        clr_cnt();
        sw_in[0] = 1'b1;
        cyc(2);
        chk("t2_db_early", db_out[0], 0);
        cyc(1);
        chk("t2_db", db_out[0], 1);
        chk("t2_rise", rise_pulse[0], 1);
        nb = 0;
        for (int j = 0; j < 20 && busy[0]; j++) begin
            nb++;
            cyc(1);
            if (j == 0) chk("t2_rise_1cyc", rise_pulse[0], 0);
        end
        chk("t2_busy_len", (nb >= 9 && nb <= 12), 1);
        chk("t2_rise_cnt", rise_cnt[0], 1);

        // 3: bounce right after a press
        sw_in[0] = 1'b0;
        cyc(20);
        clr_cnt();
        db_low = 1'b0;
        for (int j = 0; j < 6; j++) begin
            sw_in[0] = pat[j];
            cyc(1);
            if (j >= 2 && !db_out[0]) db_low = 1'b1;
        end
        for (int j = 0; j < 20; j++) begin
            cyc(1);
            if (!db_out[0]) db_low = 1'b1;
        end
        chk("t3_db_held", db_low, 0);
        chk("t3_rise_cnt", rise_cnt[0], 1);
        chk("t3_fall_cnt", fall_cnt[0], 0);

        // 4: release during WAIT1
        sw_in[0] = 1'b0;
        cyc(20);
        clr_cnt();
        sw_in[0] = 1'b1;
        cyc(5);
        chk("t4_in_wait1", {db_out[0], busy[0]}, 2'b11);
        sw_in[0] = 1'b0;
        one_cyc = 0;
        for (int j = 0; j < 20; j++) begin
            cyc(1);
            if (db_out[0] && !busy[0]) one_cyc++;
        end
        chk("t4_one_len", one_cyc, 1);
        chk("t4_db", db_out[0], 0);
        chk("t4_fall_cnt", fall_cnt[0], 1);
        cyc(15);

        // 5: simultaneous press on both channels
        sw_in = 2'b11;
        cyc(3);
        chk("t5_rise", rise_pulse, 2'b11);
        for (int j = 0; j < 15; j++) begin
            chk("t5_busy_pair", (busy == 2'b00 || busy == 2'b11), 1);
            cyc(1);
        end
        chk("t5_busy_end", busy, 2'b00);

        // 6: reset in the middle of WAIT1
        sw_in = 2'b00;
        cyc(20);
        sw_in = 2'b01;
        cyc(5);
        chk("t6_pre", busy[0], 1);
        clr_cnt();
        reset = 1'b1;
        #1;
        chk("t6_db", db_out, 0);
        chk("t6_busy", busy, 0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        chk("t6_rise_early", rise_pulse[0], 0);
        cyc(1);
        chk("t6_rise", rise_pulse[0], 1);
        chk("t6_db_rel", db_out[0], 1);
        cyc(5);
        chk("t6_fall_cnt", fall_cnt[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
